// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver with a 16x-oversampling tick, feeding a
// first-word-fall-through byte FIFO that the processor drains.
//
// Ports:
//   clk                 - system clock, rising edge
//   reset_n             - asynchronous active-low reset
//   serial_in           - asynchronous serial line, idles high
//   en_16_x_baud        - one-clk tick at 16x the baud rate
//   read_buffer         - pop one byte (ignored while the FIFO is empty)
//   data_out            - oldest FIFO byte; holds its last value when empty
//   buffer_data_present - FIFO count > 0
//   buffer_half_full    - FIFO count >= depth/2
//   buffer_full         - FIFO count == depth
//   framing_error       - one-clk pulse: stop bit sampled low, byte discarded
//   overflow            - one-clk pulse: byte dropped because the FIFO was full
module uart_rx_fifo #(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       serial_in,
  input  logic       en_16_x_baud,
  input  logic       read_buffer,
  output logic [7:0] data_out,
  output logic       buffer_data_present,
  output logic       buffer_half_full,
  output logic       buffer_full,
  output logic       framing_error,
  output logic       overflow
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   DepthCnt = (FIFO_AW + 1)'(Depth);
  localparam logic [FIFO_AW:0]   HalfCnt  = (FIFO_AW + 1)'(Depth / 2);
  localparam logic [FIFO_AW:0]   CntOne   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PtrOne   = FIFO_AW'(1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Two-flop synchroniser; only the second stage is used.
  logic sync_q, rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= serial_in;
      rx_s   <= sync_q;
    end
  end

  // Receive FSM
  state_e     state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       wr_req, fe_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      tick_cnt_q <= 4'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    wr_req     = 1'b0;
    fe_set     = 1'b0;
    if (en_16_x_baud) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_d    = StStart;
            tick_cnt_d = 4'd0;
          end
        end
        StStart: begin
          // Mid start bit: a high line here was only a glitch.
          if (tick_cnt_q == 4'd7) begin
            if (!rx_s) begin
              state_d    = StData;
              tick_cnt_d = 4'd0;
              bit_idx_d  = 3'd0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StData: begin
          if (tick_cnt_q == 4'd15) begin
            shift_d   = {rx_s, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = StStop;
          end
        end
        StStop: begin
          if (tick_cnt_q == 4'd15) begin
            if (rx_s) wr_req = 1'b1;
            else      fe_set = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FIFO
  logic [7:0]         mem [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_inc;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0]         data_q, data_d;
  logic               rd_en, wr_en, ovf_set;
  logic               fe_q, ovf_q;

  assign rd_en      = read_buffer && (count_q != '0);
  // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
  assign wr_en      = wr_req && ((count_q != DepthCnt) || rd_en);
  assign ovf_set    = wr_req && !wr_en;
  assign rd_ptr_inc = rd_ptr_q + PtrOne;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= shift_q;
  end

  always_comb begin
    count_d = count_q;
    data_d  = data_q;
    if (wr_en && !rd_en) count_d = count_q + CntOne;
    if (rd_en && !wr_en) count_d = count_q - CntOne;
    // Registered fall-through head: pick what becomes the oldest byte.
    if (rd_en) begin
      if (count_q != CntOne) data_d = mem[rd_ptr_inc];
      else if (wr_en)        data_d = shift_q;
    end else if (wr_en && (count_q == '0)) begin
      data_d = shift_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= 8'h00;
      fe_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_en) rd_ptr_q <= rd_ptr_inc;
      count_q <= count_d;
      data_q  <= data_d;
      fe_q    <= fe_set;
      ovf_q   <= ovf_set;
    end
  end

  assign data_out            = data_q;
  assign buffer_data_present = (count_q != '0);
  assign buffer_half_full    = (count_q >= HalfCnt);
  assign buffer_full         = (count_q == DepthCnt);
  assign framing_error       = fe_q;
  assign overflow            = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  logic       clk, reset_n, serial_in, en_16_x_baud, read_buffer;
  logic [7:0] data_out;
  logic       buffer_data_present, buffer_half_full, buffer_full;
  logic       framing_error, overflow;

  uart_rx_fifo #(.FIFO_AW(4)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .serial_in          (serial_in),
    .en_16_x_baud       (en_16_x_baud),
    .read_buffer        (read_buffer),
    .data_out           (data_out),
    .buffer_data_present(buffer_data_present),
    .buffer_half_full   (buffer_half_full),
    .buffer_full        (buffer_full),
    .framing_error      (framing_error),
    .overflow           (overflow)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int fe_hi = 0;
  logic [7:0] model_q [$];

  // Observations captured by send_frame around the stop sample.
  logic       obs_pre_present, obs_present, obs_half, obs_full;
  logic [7:0] obs_data;
  logic       obs_fe, obs_ov, obs_fe2, obs_ov2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (framing_error === 1'b1) fe_hi <= fe_hi + 1;

  // Tick on every posedge whose index is a multiple of 4.
  initial begin
    en_16_x_baud = 1'b0;
    forever begin
      @(negedge clk);
      en_16_x_baud = ((cyc + 1) % 4 == 0);
    end
  end

  // Frame starts on a negedge right after a tick; the stop sample lands on
  // posedge k+612, so offset 611 is just before and 612 just after it.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd);
    @(negedge clk);
    while (cyc % 4 != 0) @(negedge clk);
    for (int c = 0; c < 640; c++) begin
      if (c < 64)       serial_in = 1'b0;
      else if (c < 576) serial_in = b[(c / 64) - 1];
      else              serial_in = stop;
      read_buffer = rd && (c == 611);
      if (c == 611) obs_pre_present = buffer_data_present;
      if (c == 612) begin
        obs_present = buffer_data_present;
        obs_data    = data_out;
        obs_half    = buffer_half_full;
        obs_full    = buffer_full;
        obs_fe      = framing_error;
        obs_ov      = overflow;
      end
      if (c == 613) begin
        obs_fe2 = framing_error;
        obs_ov2 = overflow;
      end
      @(negedge clk);
    end
    serial_in   = 1'b1;
    read_buffer = 1'b0;
  endtask

  task automatic do_read();
    read_buffer = 1'b1;
    @(negedge clk);
    read_buffer = 1'b0;
  endtask

  // Model-side effect of a frame: returns whether an overflow is expected.
  function automatic logic model_frame(input logic [7:0] b, input logic stop, input logic rd);
    if (rd && model_q.size() > 0) void'(model_q.pop_front());
    if (!stop) return 1'b0;
    if (model_q.size() < 16) begin
      model_q.push_back(b);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; serial_in = 1'b1; read_buffer = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (data_out !== 8'h00) $display("FAIL reset data_out got=%h exp=00", data_out); else passes++;
    checks++; if (buffer_data_present !== 1'b0) $display("FAIL reset present got=%b exp=0", buffer_data_present); else passes++;
    checks++; if (buffer_half_full !== 1'b0) $display("FAIL reset half got=%b exp=0", buffer_half_full); else passes++;
    checks++; if (buffer_full !== 1'b0) $display("FAIL reset full got=%b exp=0", buffer_full); else passes++;
    checks++; if (framing_error !== 1'b0) $display("FAIL reset fe got=%b exp=0", framing_error); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset ovf got=%b exp=0", overflow); else passes++;
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single_frame();
    do_read();  // empty read must be ignored
    checks++; if (buffer_data_present !== 1'b0) $display("FAIL empty_read present got=%b exp=0", buffer_data_present); else passes++;
    void'(model_frame(8'h55, 1'b1, 1'b0));
    send_frame(8'h55, 1'b1, 1'b0);
    checks++; if (obs_pre_present !== 1'b0) $display("FAIL single pre_present got=%b exp=0", obs_pre_present); else passes++;
    checks++; if (obs_present !== 1'b1) $display("FAIL single present got=%b exp=1", obs_present); else passes++;
    checks++; if (obs_data !== 8'h55) $display("FAIL single data got=%h exp=55", obs_data); else passes++;
    checks++; if (obs_fe !== 1'b0) $display("FAIL single fe got=%b exp=0", obs_fe); else passes++;
    do_read(); void'(model_q.pop_front());
    checks++; if (buffer_data_present !== 1'b0) $display("FAIL single after_read present got=%b exp=0", buffer_data_present); else passes++;
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_hi;
    @(negedge clk);
    while (cyc % 4 != 0) @(negedge clk);
    serial_in = 1'b0;
    repeat (12) @(negedge clk);
    serial_in = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (buffer_data_present !== 1'b0) $display("FAIL glitch present got=%b exp=0", buffer_data_present); else passes++;
    checks++; if (fe_hi !== fe0) $display("FAIL glitch fe_cycles got=%0d exp=%0d", fe_hi, fe0); else passes++;
    void'(model_frame(8'hC3, 1'b1, 1'b0));
    send_frame(8'hC3, 1'b1, 1'b0);
    checks++; if (obs_present !== 1'b1) $display("FAIL glitch_c3 present got=%b exp=1", obs_present); else passes++;
    checks++; if (obs_data !== 8'hC3) $display("FAIL glitch_c3 data got=%h exp=c3", obs_data); else passes++;
    do_read(); void'(model_q.pop_front());
  endtask

  task automatic test_framing_error();
    int fe0;
    fe0 = fe_hi;
    void'(model_frame(8'hA3, 1'b0, 1'b0));
    send_frame(8'hA3, 1'b0, 1'b0);
    checks++; if (obs_fe !== 1'b1) $display("FAIL frame_err pulse got=%b exp=1", obs_fe); else passes++;
    checks++; if (obs_fe2 !== 1'b0) $display("FAIL frame_err width got=%b exp=0", obs_fe2); else passes++;
    checks++; if (obs_present !== 1'b0) $display("FAIL frame_err present got=%b exp=0", obs_present); else passes++;
    checks++; if (fe_hi - fe0 !== 1) $display("FAIL frame_err cycles got=%0d exp=1", fe_hi - fe0); else passes++;
  endtask

  task automatic drain_check(input string name);
    int n;
    n = model_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (data_out !== model_q[0]) $display("FAIL %s read%0d got=%h exp=%h", name, i, data_out, model_q[0]);
      else passes++;
      do_read(); void'(model_q.pop_front());
    end
    checks++;
    if ({buffer_data_present, buffer_half_full, buffer_full} !== 3'b000)
      $display("FAIL %s flags_empty got=%b exp=000", name, {buffer_data_present, buffer_half_full, buffer_full});
    else passes++;
  endtask

  task automatic test_fill_overflow();
    logic exp_ov;
    for (int i = 0; i <= 16; i++) begin
      exp_ov = model_frame(8'(i), 1'b1, 1'b0);
      send_frame(8'(i), 1'b1, 1'b0);
      checks++; if (obs_half !== (model_q.size() >= 8)) $display("FAIL fill half byte%0d got=%b exp=%b", i, obs_half, model_q.size() >= 8); else passes++;
      checks++; if (obs_full !== (model_q.size() == 16)) $display("FAIL fill full byte%0d got=%b exp=%b", i, obs_full, model_q.size() == 16); else passes++;
      checks++; if (obs_ov !== exp_ov) $display("FAIL fill ovf byte%0d got=%b exp=%b", i, obs_ov, exp_ov); else passes++;
      checks++; if (obs_ov2 !== 1'b0) $display("FAIL fill ovf_width byte%0d got=%b exp=0", i, obs_ov2); else passes++;
    end
    drain_check("fill");
  endtask

  task automatic test_rw_at_full();
    for (int i = 0; i < 16; i++) begin
      void'(model_frame(8'(i), 1'b1, 1'b0));
      send_frame(8'(i), 1'b1, 1'b0);
    end
    checks++; if (buffer_full !== 1'b1) $display("FAIL rw_full prefull got=%b exp=1", buffer_full); else passes++;
    void'(model_frame(8'h20, 1'b1, 1'b1));
    send_frame(8'h20, 1'b1, 1'b1);
    checks++; if (obs_ov !== 1'b0) $display("FAIL rw_full ovf got=%b exp=0", obs_ov); else passes++;
    checks++; if (obs_full !== 1'b1) $display("FAIL rw_full full got=%b exp=1", obs_full); else passes++;
    checks++; if (obs_data !== model_q[0]) $display("FAIL rw_full head got=%h exp=%h", obs_data, model_q[0]); else passes++;
    drain_check("rw_full");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b, r;
    r = 8'($urandom);
    void'(model_frame(r, 1'b1, 1'b0));
    send_frame(r, 1'b1, 1'b0);
    checks++; if (data_out !== r) $display("FAIL rst_mid pre_data got=%h exp=%h", data_out, r); else passes++;
    b = 8'h7E;
    @(negedge clk);
    while (cyc % 4 != 0) @(negedge clk);
    for (int c = 0; c < 340; c++) begin
      serial_in = (c < 64) ? 1'b0 : b[(c / 64) - 1];
      @(negedge clk);
    end
    reset_n = 1'b0; serial_in = 1'b1;
    model_q.delete();
    @(negedge clk);
    checks++; if (data_out !== 8'h00) $display("FAIL rst_mid data_out got=%h exp=00", data_out); else passes++;
    checks++;
    if ({buffer_data_present, buffer_half_full, buffer_full, framing_error, overflow} !== 5'b0)
      $display("FAIL rst_mid flags got=%b exp=00000",
               {buffer_data_present, buffer_half_full, buffer_full, framing_error, overflow});
    else passes++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (buffer_data_present !== 1'b0) $display("FAIL rst_mid idle_present got=%b exp=0", buffer_data_present); else passes++;
    void'(model_frame(8'h81, 1'b1, 1'b0));
    send_frame(8'h81, 1'b1, 1'b0);
    checks++; if (obs_data !== 8'h81) $display("FAIL rst_mid data got=%h exp=81", obs_data); else passes++;
    drain_check("rst_mid");
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop, exp_ov;
    int         nrd;
    for (int i = 0; i < 8; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      exp_ov = model_frame(b, stop, 1'b0);
      send_frame(b, stop, 1'b0);
      checks++; if (obs_fe !== !stop) $display("FAIL rand fe frame%0d got=%b exp=%b", i, obs_fe, !stop); else passes++;
      checks++; if (obs_ov !== exp_ov) $display("FAIL rand ovf frame%0d got=%b exp=%b", i, obs_ov, exp_ov); else passes++;
      checks++; if (obs_present !== (model_q.size() > 0)) $display("FAIL rand present frame%0d got=%b exp=%b", i, obs_present, model_q.size() > 0); else passes++;
      if (model_q.size() > 0) begin
        checks++; if (obs_data !== model_q[0]) $display("FAIL rand head frame%0d got=%h exp=%h", i, obs_data, model_q[0]); else passes++;
      end
      nrd = $urandom_range(0, 2);
      for (int k = 0; k < nrd; k++) begin
        do_read();
        if (model_q.size() > 0) void'(model_q.pop_front());
        if (model_q.size() > 0) begin
          checks++; if (data_out !== model_q[0]) $display("FAIL rand pop frame%0d got=%h exp=%h", i, data_out, model_q[0]); else passes++;
        end
      end
    end
    drain_check("rand");
  endtask

  initial begin
    reset_n = 1'b0; serial_in = 1'b1; read_buffer = 1'b0;
    test_reset();
    test_single_frame();
    test_glitch();
    test_framing_error();
    test_fill_overflow();
    test_rw_at_full();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
